uart_rx_engine: RTL and testbench

Serial receive engine for the UART link; it is the counterpart of the transmit path. It synchronizes the RX line, detects and qualifies the start bit, and samples each bit at mid-bit using a bit-time counter. It then assembles an 8-bit LSB-first character, checks the stop bit and optional parity, and presents the byte with a ready flag to the host-side register logic. Status flags report parity, framing and overrun errors.

---
 rtl/uart_rx_engine_if.sv | 30 +++
 rtl/uart_rx_engine.sv | 152 +++++++++++++++
 tb/tb_uart_rx_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_engine_if.sv
// Host-side register interface of the UART receive engine.
// RXRDY is the valid flag for RDATA/PERR/FERR/OVF.
// READ is a one-cycle acknowledge that is honoured only while RXRDY is high.
// A completion in the same cycle as READ takes precedence over the acknowledge.
interface uart_rx_engine_if;
    logic       READ;
    logic [7:0] RDATA;
    logic       RXRDY;
    logic       PERR;
    logic       FERR;
    logic       OVF;

    modport slave (
        input  READ,
        output RDATA,
        output RXRDY,
        output PERR,
        output FERR,
        output OVF
    );

    modport master (
        output READ,
        input  RDATA,
        input  RXRDY,
        input  PERR,
        input  FERR,
        input  OVF
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-flop RX synchronizer, mid-bit sampling, 8-bit LSB-first framing.
// Define RX_PARITY_EN to add a parity bit between data bit 7 and the stop bit.
module uart_rx_engine #(
    parameter int BAUD_DIV   = 10416,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RX,
    uart_rx_engine_if.slave   host,
    output logic [2:0]        state_dbg
);
    localparam int BT_W = $clog2(BAUD_DIV);
    localparam logic [BT_W-1:0] BT_HALF = BT_W'(BAUD_DIV / 2 - 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BRK    = 3'd4
`ifdef RX_PARITY_EN
        , PARITY = 3'd5
`endif
    } state_t;

    state_t          state, state_n;
    logic            rx_meta, rxs;
    logic [BT_W-1:0] bt, bt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            complete;
`ifdef RX_PARITY_EN
    logic            perr_q, perr_n;
`endif

    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        bt_n      = bt + BT_W'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        complete  = 1'b0;
`ifdef RX_PARITY_EN
        perr_n    = perr_q;
`endif
        case (state)
            IDLE: begin
                bt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (bt == BT_HALF) begin
                    bt_n = '0;
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = 3'd0;
                    end
                end
            end
            DATA: begin
                if (bt == BT_LAST) begin
                    bt_n      = '0;
                    shreg_n   = {rxs, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bt == BT_LAST) begin
                    bt_n    = '0;
                    perr_n  = ((^shreg) ^ rxs) != ODD_PARITY[0];
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bt == BT_LAST) begin
                    bt_n     = '0;
                    complete = 1'b1;
                    state_n  = rxs ? IDLE : BRK;
                end
            end
            BRK: begin
                // A held-low line must not be decoded as a stream of 8'h00 frames.
                bt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                bt_n    = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            bt         <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
`ifdef RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
            host.RDATA <= 8'h00;
            host.RXRDY <= 1'b0;
            host.PERR  <= 1'b0;
            host.FERR  <= 1'b0;
            host.OVF   <= 1'b0;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
            state   <= state_n;
            bt      <= bt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
`ifdef RX_PARITY_EN
            perr_q  <= perr_n;
`endif
            if (complete) begin
                // Completion wins over a coincident READ; errored frames are still delivered.
                host.RDATA <= shreg;
                host.RXRDY <= 1'b1;
`ifdef RX_PARITY_EN
                host.PERR  <= perr_q;
`else
                host.PERR  <= 1'b0;
`endif
                host.FERR  <= ~rxs;
                host.OVF   <= host.RXRDY & ~host.READ;
            end else if (host.READ && host.RXRDY) begin
                host.RXRDY <= 1'b0;
                host.PERR  <= 1'b0;
                host.FERR  <= 1'b0;
                host.OVF   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine at BAUD_DIV=16; follows RX_PARITY_EN if defined.
module tb_uart_rx_engine;
    localparam int BD = 16;
`ifdef RX_PARITY_EN
    localparam int NBITS    = 11;
    localparam int RISE_CYC = 171;
`else
    localparam int NBITS    = 10;
    localparam int RISE_CYC = 155;
`endif
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BRK  = 3'd4;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [2:0] state_dbg;
    int         checks;
    int         errors;
    int         rdy_cyc;

    uart_rx_engine_if hif ();

    uart_rx_engine #(.BAUD_DIV(BD), .ODD_PARITY(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .RX        (rx),
        .host      (hif.slave),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one frame starting at a falling clock edge; stop_after>0 truncates it.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                              input int read_at, input int stop_after);
        logic [10:0] bits;
        logic        par;
        int          ncyc;
        par  = (^d) ^ bad_par;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef RX_PARITY_EN
        bits[9]  = par;
        bits[10] = stop_bit;
`else
        bits[9]  = stop_bit;
`endif
        ncyc = NBITS * BD;
        if (stop_after > 0 && stop_after < ncyc) ncyc = stop_after;
        rdy_cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            rx = bits[c / BD];
            hif.READ = (c == read_at);
            @(negedge clk);
            if (rdy_cyc < 0 && hif.RXRDY === 1'b1) rdy_cyc = c + 1;
        end
        hif.READ = 1'b0;
        rx = (stop_after > 0) ? 1'b1 : stop_bit;
    endtask

    task automatic pulse_read();
        hif.READ = 1'b1;
        @(negedge clk);
        hif.READ = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic left_idle;
        reset = 1'b1; rx = 1'b1; hif.READ = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        left_idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state_dbg !== S_IDLE) left_idle = 1'b1;
        end
        checks++; if (left_idle !== 1'b0) begin errors++; $display("FAIL reset_idle left IDLE got %0b exp 0", left_idle); end
        checks++; if (hif.RXRDY !== 1'b0) begin errors++; $display("FAIL reset_rxrdy got %0b exp 0", hif.RXRDY); end
        checks++; if (hif.RDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", hif.RDATA); end
        checks++; if ({hif.PERR, hif.FERR, hif.OVF} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {hif.PERR, hif.FERR, hif.OVF}); end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
        checks++; if (rdy_cyc !== RISE_CYC) begin errors++; $display("FAIL basic_rise_cycle got %0d exp %0d", rdy_cyc, RISE_CYC); end
        checks++; if (hif.RDATA !== 8'hA5) begin errors++; $display("FAIL basic_rdata got %h exp a5", hif.RDATA); end
        checks++; if ({hif.PERR, hif.FERR, hif.OVF} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b exp 000", {hif.PERR, hif.FERR, hif.OVF}); end
        pulse_read();
        checks++; if (hif.RXRDY !== 1'b0) begin errors++; $display("FAIL basic_read_clear got %0b exp 0", hif.RXRDY); end
        checks++; if (hif.RDATA !== 8'hA5) begin errors++; $display("FAIL basic_rdata_hold got %h exp a5", hif.RDATA); end
    endtask

    task automatic test_glitch();
        logic saw_data;
        saw_data = 1'b0;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state_dbg === S_DATA) saw_data = 1'b1;
        end
        checks++; if (saw_data !== 1'b0) begin errors++; $display("FAIL glitch_data_entry got %0b exp 0", saw_data); end
        checks++; if (hif.RXRDY !== 1'b0 || hif.FERR !== 1'b0) begin errors++; $display("FAIL glitch_flags rxrdy %0b ferr %0b exp 0 0", hif.RXRDY, hif.FERR); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL glitch_state got %0d exp 0", state_dbg); end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0);
        repeat (40) @(negedge clk);
        checks++; if (state_dbg !== S_BRK) begin errors++; $display("FAIL frame_brk_state got %0d exp 4", state_dbg); end
        checks++; if (hif.RDATA !== 8'h3C) begin errors++; $display("FAIL frame_rdata got %h exp 3c", hif.RDATA); end
        checks++; if ({hif.RXRDY, hif.PERR, hif.FERR, hif.OVF} !== 4'b1010) begin errors++; $display("FAIL frame_flags rdy/perr/ferr/ovf got %b exp 1010", {hif.RXRDY, hif.PERR, hif.FERR, hif.OVF}); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL frame_idle_after_brk got %0d exp 0", state_dbg); end
        checks++; if (hif.OVF !== 1'b0 || hif.RDATA !== 8'h3C) begin errors++; $display("FAIL frame_no_second ovf %0b rdata %h exp 0 3c", hif.OVF, hif.RDATA); end
        pulse_read();
        checks++; if (hif.RXRDY !== 1'b0 || hif.FERR !== 1'b0) begin errors++; $display("FAIL frame_read_clear rxrdy %0b ferr %0b exp 0 0", hif.RXRDY, hif.FERR); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h01, 1'b1, 1'b0, -1, 0);
        checks++; if (hif.RDATA !== 8'h01 || hif.OVF !== 1'b0) begin errors++; $display("FAIL b2b_first rdata %h ovf %0b exp 01 0", hif.RDATA, hif.OVF); end
        send_frame(8'h02, 1'b1, 1'b0, -1, 0);
        checks++; if (hif.RDATA !== 8'h02) begin errors++; $display("FAIL b2b_rdata got %h exp 02", hif.RDATA); end
        checks++; if ({hif.RXRDY, hif.FERR, hif.OVF} !== 3'b101) begin errors++; $display("FAIL b2b_overrun rdy/ferr/ovf got %b exp 101", {hif.RXRDY, hif.FERR, hif.OVF}); end
        pulse_read();
        checks++; if ({hif.RXRDY, hif.PERR, hif.FERR, hif.OVF} !== 4'b0000) begin errors++; $display("FAIL b2b_read_clear got %b exp 0000", {hif.RXRDY, hif.PERR, hif.FERR, hif.OVF}); end
        pulse_read();
        checks++; if (hif.RDATA !== 8'h02 || hif.RXRDY !== 1'b0) begin errors++; $display("FAIL b2b_idle_read rdata %h rxrdy %0b exp 02 0", hif.RDATA, hif.RXRDY); end
    endtask

    task automatic test_read_collision();
        send_frame(8'h11, 1'b1, 1'b0, -1, 0);
        send_frame(8'h22, 1'b1, 1'b0, RISE_CYC - 1, 0);
        checks++; if ({hif.RXRDY, hif.OVF} !== 2'b10) begin errors++; $display("FAIL collide_flags rdy/ovf got %b exp 10", {hif.RXRDY, hif.OVF}); end
        checks++; if (hif.RDATA !== 8'h22) begin errors++; $display("FAIL collide_rdata got %h exp 22", hif.RDATA); end
        pulse_read();
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1, -1, 0);
        checks++; if (hif.PERR !== 1'b1) begin errors++; $display("FAIL parity_perr got %0b exp 1", hif.PERR); end
        checks++; if (hif.RDATA !== 8'h07 || hif.FERR !== 1'b0) begin errors++; $display("FAIL parity_rdata rdata %h ferr %0b exp 07 0", hif.RDATA, hif.FERR); end
        pulse_read();
        checks++; if (hif.PERR !== 1'b0) begin errors++; $display("FAIL parity_read_clear got %0b exp 0", hif.PERR); end
    endtask
`endif

    task automatic test_reset_mid();
        send_frame(8'h5A, 1'b1, 1'b0, -1, 0);
        send_frame(8'h55, 1'b1, 1'b0, -1, BD + 3 * BD + 5);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (hif.RXRDY !== 1'b0 || hif.RDATA !== 8'h00) begin errors++; $display("FAIL midreset_out rxrdy %0b rdata %h exp 0 00", hif.RXRDY, hif.RDATA); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL midreset_state got %0d exp 0", state_dbg); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b0, -1, 0);
        checks++; if (hif.RDATA !== 8'h55 || rdy_cyc !== RISE_CYC) begin errors++; $display("FAIL midreset_fresh rdata %h rise %0d exp 55 %0d", hif.RDATA, rdy_cyc, RISE_CYC); end
        checks++; if ({hif.PERR, hif.FERR, hif.OVF} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b exp 000", {hif.PERR, hif.FERR, hif.OVF}); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rdy_cyc  = -1;
        reset    = 1'b1;
        rx       = 1'b1;
        hif.READ = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_read_collision();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
